// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready handshake on both sides.
// Simple ops (add/sub/compare/logic/shift) complete one cycle after
// acceptance. MUL (shift-add) and DIVU (restoring) run iteratively for
// WIDTH cycles and take WIDTH+1 cycles.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operation handshake (alufn, a, b)
//   out_valid / out_ready result handshake (result, zero, ovf, dbz, illegal)
//   busy                 high while a MUL or DIV iteration is in progress
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             dbz,
  output logic             illegal,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIVU, OP_EQ, OP_LT, OP_LE,
    OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SRA, OP_ILL
  } op_e;

  state_e           state;
  op_e              op;
  logic             rdy_en;   // low until the first clock after reset release
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;       // MUL: product high half; DIV: remainder
  logic [WIDTH-1:0] lo;       // MUL: multiplier/product low; DIV: dividend/quotient
  logic [WIDTH-1:0] opnd;     // MUL: multiplicand; DIV: divisor

  logic             accept;
  logic [WIDTH-1:0] sum, dif;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] s_res;
  logic             s_ovf, s_dbz, s_ill;

  logic [WIDTH:0]   madd, dsh, ddif;
  logic [WIDTH-1:0] hi_nx, lo_nx;

  assign in_ready = rdy_en && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Opcode bit 4 is a don't-care.
  always_comb begin
    op = OP_ILL;
    casez (alufn)
      6'b1?0000: op = OP_ADD;
      6'b1?0001: op = OP_SUB;
      6'b1?0010: op = OP_MUL;
      6'b1?0011: op = OP_DIVU;
      6'b1?0100: op = OP_EQ;
      6'b1?0101: op = OP_LT;
      6'b1?0110: op = OP_LE;
      6'b1?1000: op = OP_AND;
      6'b1?1001: op = OP_OR;
      6'b1?1010: op = OP_XOR;
      6'b1?1100: op = OP_SHL;
      6'b1?1101: op = OP_SHR;
      6'b1?1110: op = OP_SRA;
      default:   op = OP_ILL;
    endcase
  end

  assign sum   = a + b;
  assign dif   = a - b;
  assign shamt = b[SHW-1:0];

  // Single-cycle results; DIVU here only covers the divide-by-zero case.
  always_comb begin
    s_res = '0;
    s_ovf = 1'b0;
    s_dbz = 1'b0;
    s_ill = 1'b0;
    case (op)
      OP_ADD: begin
        s_res = sum;
        s_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = dif;
        s_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_DIVU: begin
        s_res = '1;
        s_dbz = 1'b1;
      end
      OP_EQ:  s_res[0] = (a == b);
      OP_LT:  s_res[0] = ($signed(a) <  $signed(b));
      OP_LE:  s_res[0] = ($signed(a) <= $signed(b));
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_SHL: s_res = a << shamt;
      OP_SHR: s_res = a >> shamt;
      OP_SRA: s_res = $signed(a) >>> shamt;
      OP_MUL: s_res = '0;
      default: s_ill = 1'b1;
    endcase
  end

  // One iteration step of either shift-add multiply or restoring divide.
  always_comb begin
    madd = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    dsh  = {hi, lo[WIDTH-1]};
    ddif = dsh - {1'b0, opnd};
    if (state == DIV) begin
      if (!ddif[WIDTH]) begin
        hi_nx = ddif[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = dsh[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = madd[WIDTH:1];
      lo_nx = {madd[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      illegal   <= 1'b0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state <= MULT;
              hi    <= '0;
              lo    <= b;
              opnd  <= a;
              cnt   <= '0;
            end else if (op == OP_DIVU && b != '0) begin
              state <= DIV;
              hi    <= '0;
              lo    <= a;
              opnd  <= b;
              cnt   <= '0;
            end else begin
              result    <= s_res;
              zero      <= (s_res == '0);
              ovf       <= s_ovf;
              dbz       <= s_dbz;
              illegal   <= s_ill;
              out_valid <= 1'b1;
            end
          end
        end
        MULT, DIV: begin
          if (cnt != LAST) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + CW'(1);
          end else if (!out_valid || out_ready) begin
            // Final step is only taken once the output register is free,
            // so a pending result is never overwritten.
            hi        <= hi_nx;
            lo        <= lo_nx;
            result    <= lo_nx;
            zero      <= (lo_nx == '0);
            ovf       <= (state == MULT) && (hi_nx != '0);
            dbz       <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed vector table,
// hand-written multi-cycle/handshake sequences, and randomized ops checked
// against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   alufn = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, ovf, dbz, illegal, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alufn(alufn), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .dbz(dbz), .illegal(illegal),
    .busy(busy)
  );

  typedef struct {
    logic [5:0]  f;
    logic [31:0] x, y, res;
    logic        z, o, d, il;
    int          lat;
    int          stall;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] f, input logic [31:0] x, y, res,
                              input logic z, o, d, il, input int lat, stall);
    vec_t v;
    v.f = f; v.x = x; v.y = y; v.res = res;
    v.z = z; v.o = o; v.d = d; v.il = il;
    v.lat = lat; v.stall = stall;
    return v;
  endfunction

  // Reference model: plain wide arithmetic on the opcode's meaning.
  function automatic vec_t model(input logic [5:0] f, input logic [31:0] x, y);
    vec_t        e;
    longint      s;
    logic [63:0] p;
    e = mk(f, x, y, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    if (!f[5]) e.il = 1'b1;
    else begin
      case (f[3:0])
        4'h0: begin
          e.res = x + y;
          s = longint'($signed(x)) + longint'($signed(y));
          e.o = (s != longint'($signed(e.res)));
        end
        4'h1: begin
          e.res = x - y;
          s = longint'($signed(x)) - longint'($signed(y));
          e.o = (s != longint'($signed(e.res)));
        end
        4'h2: begin
          p = {32'h0, x} * {32'h0, y};
          e.res = p[31:0];
          e.o = (p[63:32] != 0);
          e.lat = 33;
        end
        4'h3: begin
          if (y == 0) begin e.res = 32'hFFFFFFFF; e.d = 1'b1; end
          else begin e.res = x / y; e.lat = 33; end
        end
        4'h4: e.res = (x == y) ? 1 : 0;
        4'h5: e.res = ($signed(x) <  $signed(y)) ? 1 : 0;
        4'h6: e.res = ($signed(x) <= $signed(y)) ? 1 : 0;
        4'h8: e.res = x & y;
        4'h9: e.res = x | y;
        4'hA: e.res = x ^ y;
        4'hC: e.res = x << y[4:0];
        4'hD: e.res = x >> y[4:0];
        4'hE: e.res = $signed(x) >>> y[4:0];
        default: e.il = 1'b1;
      endcase
    end
    e.z = (e.res == 0);
    return e;
  endfunction

  // Called #1 after a rising edge with no output pending.
  task automatic run_op(input string tag, input vec_t v);
    int          lat;
    int          nbusy;
    logic [31:0] held;
    in_valid = 1'b1; alufn = v.f; a = v.x; b = v.y; out_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must have no effect.
    in_valid = 1'b0; alufn = 6'($urandom); a = $urandom; b = $urandom;
    lat = 1; nbusy = 0;
    while (!out_valid && lat < 200) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s.latency", tag), 64'(lat), 64'(v.lat));
    chk($sformatf("%s.busy_cycles", tag), 64'(nbusy), 64'((v.lat == 1) ? 0 : v.lat - 1));
    chk($sformatf("%s.result", tag), 64'(result), 64'(v.res));
    chk($sformatf("%s.zero", tag), 64'(zero), 64'(v.z));
    chk($sformatf("%s.ovf", tag), 64'(ovf), 64'(v.o));
    chk($sformatf("%s.dbz", tag), 64'(dbz), 64'(v.d));
    chk($sformatf("%s.illegal", tag), 64'(illegal), 64'(v.il));
    held = result;
    for (int s = 0; s < v.stall; s++) begin
      in_valid = 1'b1; alufn = 6'b100000; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk($sformatf("%s.stall_hold", tag), 64'(result), 64'(held));
      chk($sformatf("%s.stall_valid", tag), 64'(out_valid), 64'(1));
      chk($sformatf("%s.stall_in_ready", tag), 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("%s.valid_clear", tag), 64'(out_valid), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        v;
    logic [5:0]  codes[13];
    logic [5:0]  f;
    logic [31:0] x, y;
    int          r;

    codes = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
              6'b100110, 6'b101000, 6'b101001, 6'b101010, 6'b101100, 6'b101101,
              6'b101110};

    // Reset state
    #12;
    chk("rst.out_valid", 64'(out_valid), 0);
    chk("rst.in_ready", 64'(in_ready), 0);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.result", 64'(result), 0);
    chk("rst.flags", 64'({zero, ovf, dbz, illegal}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready_after_release", 64'(in_ready), 1);

    // Directed table: f, a, b, result, zero, ovf, dbz, illegal, latency, stall
    tbl.push_back(mk(6'b100000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, 0, 1,  0));
    tbl.push_back(mk(6'b110000, 32'h1,        32'h2,        32'h3,        0, 0, 0, 0, 1,  0));
    tbl.push_back(mk(6'b100001, 32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, 0, 0, 1,  0));
    tbl.push_back(mk(6'b100010, 32'h00010000, 32'h00010000, 32'h0,        1, 1, 0, 0, 33, 0));
    tbl.push_back(mk(6'b100010, 32'h3,        32'h5,        32'hF,        0, 0, 0, 0, 33, 2));
    tbl.push_back(mk(6'b100011, 32'd100,      32'd7,        32'd14,       0, 0, 0, 0, 33, 0));
    tbl.push_back(mk(6'b100011, 32'h1234,     32'h0,        32'hFFFFFFFF, 0, 0, 1, 0, 1,  0));
    tbl.push_back(mk(6'b100011, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 0, 0, 0, 0, 33, 0));
    tbl.push_back(mk(6'b000111, 32'h55,       32'h66,       32'h0,        1, 0, 0, 1, 1,  5));
    tbl.push_back(mk(6'b100111, 32'h55,       32'h66,       32'h0,        1, 0, 0, 1, 1,  0));
    tbl.push_back(mk(6'b100110, 32'h5,        32'h5,        32'h1,        0, 0, 0, 0, 1,  0));
    tbl.push_back(mk(6'b100100, 32'h3,        32'h4,        32'h0,        1, 0, 0, 0, 1,  0));
    tbl.push_back(mk(6'b101100, 32'h1,        32'h1F,       32'h80000000, 0, 0, 0, 0, 1,  0));
    tbl.push_back(mk(6'b101101, 32'h80000000, 32'h20,       32'h80000000, 0, 0, 0, 0, 1,  0));
    tbl.push_back(mk(6'b101000, 32'hF0F0,     32'hFF00,     32'hF000,     0, 0, 0, 0, 1,  0));
    tbl.push_back(mk(6'b101001, 32'h0F00,     32'h00F0,     32'h0FF0,     0, 0, 0, 0, 1,  0));
    tbl.push_back(mk(6'b101010, 32'hABCD,     32'hABCD,     32'h0,        1, 0, 0, 0, 1,  0));
    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back simple ops at full throughput
    in_valid = 1'b1; out_ready = 1'b1;
    alufn = 6'b100001; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    chk("b2b.sub.valid", 64'(out_valid), 1);
    chk("b2b.sub.result", 64'(result), 0);
    chk("b2b.sub.zero", 64'(zero), 1);
    chk("b2b.in_ready", 64'(in_ready), 1);
    alufn = 6'b100101; a = 32'hFFFFFFFF; b = 32'h1;
    @(posedge clk); #1;
    chk("b2b.cmplt.valid", 64'(out_valid), 1);
    chk("b2b.cmplt.result", 64'(result), 1);
    alufn = 6'b101110; a = 32'h80000000; b = 32'h4;
    @(posedge clk); #1;
    chk("b2b.sra.valid", 64'(out_valid), 1);
    chk("b2b.sra.result", 64'(result), 64'h00000000F8000000);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b.drain", 64'(out_valid), 0);
    out_ready = 1'b0;

    // Reset in the middle of a multiply
    in_valid = 1'b1; alufn = 6'b100010; a = 32'h3; b = 32'h5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rstmul.busy_before", 64'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmul.out_valid", 64'(out_valid), 0);
    chk("rstmul.busy", 64'(busy), 0);
    chk("rstmul.in_ready", 64'(in_ready), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmul.ready", 64'(in_ready), 1);
    run_op("rstmul.add", mk(6'b100000, 32'h2, 32'h3, 32'h5, 0, 0, 0, 0, 1, 0));

    // Randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      if (r < 13) f = codes[r] | (($urandom % 2 == 1) ? 6'b010000 : 6'b000000);
      else if (r == 13) f = {1'b0, 5'($urandom)};
      else f = 6'($urandom);
      x = $urandom;
      y = ($urandom % 4 == 0) ? 32'($urandom % 8) : 32'($urandom);
      if ($urandom % 8 == 0) x = 32'($urandom % 300);
      v = model(f, x, y);
      v.stall = $urandom_range(0, 2);
      run_op($sformatf("rnd%0d_f%0b", i, f), v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
